// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe: valid/ready in, valid/ready out.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Define CLA_OVERFLOW_EN to generate the registered signed-overflow flag; otherwise it reads 0.
module cla_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    cla_adder_pipe_if.slave   bus
);
    localparam int NG = WIDTH / 4;

    function automatic logic [1:0] grp_pg(input logic [3:0] p, input logic [3:0] g);
        logic gp;
        logic gg;
        gp = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gp, gg};
    endfunction

    // Carries into each bit of a 4-bit group, given the group carry-in.
    function automatic logic [3:0] grp_carry(input logic [3:0] p, input logic [3:0] g,
                                             input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [WIDTH-1:0] b_eff_p0, p_p0, g_p0;
    logic [NG-1:0]    gp_p0, gg_p0;
    logic             cin_p0;

    logic [WIDTH-1:0] p_p1_q, g_p1_q;
    logic [NG-1:0]    gp_p1_q, gg_p1_q;
    logic             cin_p1_q;
    logic             vld_p1_q, vld_p1_d;

    logic [WIDTH-1:0] carry_p1;
    logic             cout_p1;

    logic [WIDTH-1:0] sum_p2_q;
    logic             cout_p2_q;
    logic             vld_p2_q, vld_p2_d;

    logic             s2_load, in_ready, accept;

    // Stage 0: operand conditioning and first-level group propagate/generate
    always_comb begin
        b_eff_p0 = bus.sub ? ~bus.b : bus.b;
        cin_p0   = bus.sub ^ bus.c_in;
        p_p0     = bus.a ^ b_eff_p0;
        g_p0     = bus.a & b_eff_p0;
        gp_p0    = '0;
        gg_p0    = '0;
        for (int k = 0; k < NG; k++) begin
            {gp_p0[k], gg_p0[k]} = grp_pg(p_p0[4*k +: 4], g_p0[4*k +: 4]);
        end
    end

    assign s2_load  = vld_p1_q & (~vld_p2_q | bus.out_ready);
    assign in_ready = ~rst & (~vld_p1_q | s2_load);
    assign accept   = bus.in_valid & in_ready;
    assign vld_p1_d = accept | (vld_p1_q & ~s2_load);
    assign vld_p2_d = s2_load | (vld_p2_q & ~bus.out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
        end
    end

    // Stage 1: datapath register, loaded only on an accepted beat
    always_ff @(posedge clk) begin
        if (accept) begin
            p_p1_q   <= p_p0;
            g_p1_q   <= g_p0;
            gp_p1_q  <= gp_p0;
            gg_p1_q  <= gg_p0;
            cin_p1_q <= cin_p0;
        end
    end

    // Second-level lookahead across groups, then per-group bit carries
    always_comb begin
        logic gc;
        gc       = cin_p1_q;
        carry_p1 = '0;
        for (int k = 0; k < NG; k++) begin
            carry_p1[4*k +: 4] = grp_carry(p_p1_q[4*k +: 4], g_p1_q[4*k +: 4], gc);
            gc = gg_p1_q[k] | (gp_p1_q[k] & gc);
        end
        cout_p1 = gc;
    end

    // Stage 2: result registers, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p2_q  <= '0;
            cout_p2_q <= 1'b0;
        end else if (s2_load) begin
            sum_p2_q  <= p_p1_q ^ carry_p1;
            cout_p2_q <= cout_p1;
        end
    end

`ifdef CLA_OVERFLOW_EN
    logic ov_p2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_p2_q <= 1'b0;
        end else if (s2_load) begin
            ov_p2_q <= carry_p1[WIDTH-1] ^ cout_p1;
        end
    end

    assign bus.overflow = ov_p2_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p2_q;
    assign bus.sum       = sum_p2_q;
    assign bus.c_out     = cout_p2_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Randomized and directed bench for cla_adder_pipe against an integer-arithmetic reference.
module tb_cla_adder_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cla_adder_pipe_if #(.WIDTH(W)) bus();

    cla_adder_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
        exp_t   e;
        longint ua, ub, sa, sb, ci, r, sr;
        logic [63:0] rbits;
        ua = av;
        ub = bv;
        sa = $signed(av);
        sb = $signed(bv);
        ci = cv;
        if (!sv) begin
            r    = ua + ub + ci;
            e.co = (r >= (longint'(1) << W));
            sr   = sa + sb + ci;
        end else begin
            r    = ua - ub - ci;
            e.co = (r >= 0);
            sr   = sa - sb - ci;
        end
        rbits = r;
        e.s   = rbits[W-1:0];
`ifdef CLA_OVERFLOW_EN
        e.ov = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
`else
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", bus.sum, e.s);
                    chk("c_out", bus.c_out, e.co);
                    chk("overflow", bus.overflow, e.ov);
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input bit rnd);
        int   n;
        logic rdy;
        n = 0;
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.c_in = cv;
        bus.sub = sv;
        do begin
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    // Directed beat into an empty pipe with out_ready high: result one edge after accept.
    task automatic one(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic sv,
                       input logic [W-1:0] es, input logic eco, input logic eov);
        send(av, bv, cv, sv, 1'b0);
        chk({tag, "_lat0"}, bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_sum"}, bus.sum, es);
        chk({tag, "_cout"}, bus.c_out, eco);
        chk({tag, "_ovf"}, bus.overflow, eov);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        int   idx, acc, n;
        logic ovf_exp;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
`ifdef CLA_OVERFLOW_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.c_out, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        one("add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        one("sub_borrow", 16'd5, 16'd7, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        one("sub_bin", 16'd7, 16'd5, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, ovf_exp);
        one("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, ovf_exp);
        wait_drain("directed_drain");

        // Backpressure: four back-to-back beats into a stalled consumer
        bus.out_ready = 1'b0;
        idx = 1;
        acc = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.a = W'(idx);
            bus.b = '0;
            bus.c_in = 1'b0;
            bus.sub = 1'b0;
            @(negedge clk);
            if (bus.in_ready) begin
                acc++;
                idx++;
            end
            @(posedge clk);
            #1;
        end
        bus.a = W'(idx);
        chk("bp_accepts", acc, 2);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_held_valid", bus.out_valid, 1);
        chk("bp_held_sum", bus.sum, 1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_comb_ready", bus.in_ready, 1);
        n = 0;
        while (idx <= 4 && n < 20) begin
            bus.a = W'(idx);
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("bp_all_sent", idx, 5);
        wait_drain("bp_drain");

        // Reset with both stages occupied
        bus.out_ready = 1'b0;
        send(16'd10, 16'd20, 1'b0, 1'b0, 1'b0);
        send(16'd30, 16'd40, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_sum", bus.sum, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        one("after_rst", 16'd3, 16'd4, 1'b0, 1'b0, 16'd7, 1'b0, 1'b0);
        wait_drain("rst_drain");

        // Random traffic with random idle gaps and consumer stalls
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.c_in = 1'($urandom);
                bus.sub = 1'($urandom);
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        bus.out_ready = 1'b1;
        wait_drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
